// File: rtl/gb_timer_pkg.sv
// Shared definitions for the DIV/TIMA/TMA/TAC timer block: register map,
// clock-select table and sequencer state encoding.
package gb_timer_pkg;

    localparam int unsigned ADR_W   = 16;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned CNT_W   = 16;
    localparam int unsigned TAC_W   = 3;
    localparam int unsigned OVF_W   = 2;
    localparam int unsigned BITSEL_W = 4;

    localparam logic [1:0] OFF_DIV  = 2'd0;
    localparam logic [1:0] OFF_TIMA = 2'd1;
    localparam logic [1:0] OFF_TMA  = 2'd2;
    localparam logic [1:0] OFF_TAC  = 2'd3;

    // OVF lasts this many cycles plus one before the reload cycle
    localparam logic [OVF_W-1:0] OVF_LAST = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_OVF    = 2'd1,
        ST_RELOAD = 2'd2
    } state_t;

    // Counter bit whose falling edge clocks TIMA for each TAC clock select
    function automatic logic [BITSEL_W-1:0] tac_bit_sel(input logic [1:0] clk_sel);
        logic [BITSEL_W-1:0] bit_idx;
        case (clk_sel)
            2'b00:   bit_idx = BITSEL_W'(9);
            2'b01:   bit_idx = BITSEL_W'(3);
            2'b10:   bit_idx = BITSEL_W'(5);
            default: bit_idx = BITSEL_W'(7);
        endcase
        return bit_idx;
    endfunction

endpackage

// File: rtl/gb_timer_prescaler.sv
// Free-running 16-bit divider with TAC-selected tap and falling-edge tick;
// clearing the counter or changing TAC can itself produce a tick.
module gb_timer_prescaler
    import gb_timer_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              div_clr,
    input  logic [TAC_W-1:0]  tac,
    output logic [DATA_W-1:0] div,
    output logic              tick_c
);

    logic [CNT_W-1:0] cnt;
    logic             tick_sel_c;
    logic             tick_sel_d;

    always_comb begin
        tick_sel_c = cnt[tac_bit_sel(tac[1:0])] & tac[2];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= '0;
            tick_sel_d <= 1'b0;
        end else begin
            cnt        <= div_clr ? '0 : cnt + CNT_W'(1);
            tick_sel_d <= tick_sel_c;
        end
    end

    assign tick_c = tick_sel_d & ~tick_sel_c;
    assign div    = cnt[CNT_W-1 -: DATA_W];

endmodule

// File: rtl/gb_timer.sv
// Timer register block: DIV, TIMA, TMA, TAC with the delayed TMA reload and
// one-cycle interrupt pulse after a TIMA overflow.
module gb_timer
    import gb_timer_pkg::*;
#(
    parameter logic [ADR_W-1:0] BASE = 16'hFF04
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADR_W-1:0]  adr,
    input  logic [DATA_W-1:0] din,
    input  logic              read,
    input  logic              write,
    output logic [DATA_W-1:0] dout,
    output logic              dsel,
    output logic              irq
);

    logic              hit_c;
    logic [1:0]        off_c;
    logic              wr_c;
    logic              div_wr_c, tima_wr_c, tma_wr_c, tac_wr_c;
    logic              tick_c;
    logic [DATA_W-1:0] div_c;

    logic [DATA_W-1:0] tima, tima_n;
    logic [DATA_W-1:0] tma,  tma_n;
    logic [TAC_W-1:0]  tac,  tac_n;
    logic [OVF_W-1:0]  ovf_cnt, ovf_cnt_n;
    logic              irq_n;
    state_t            state, state_n;

    assign hit_c     = (adr[ADR_W-1:2] == BASE[ADR_W-1:2]);
    assign off_c     = adr[1:0];
    assign wr_c      = write & hit_c;
    assign div_wr_c  = wr_c & (off_c == OFF_DIV);
    assign tima_wr_c = wr_c & (off_c == OFF_TIMA);
    assign tma_wr_c  = wr_c & (off_c == OFF_TMA);
    assign tac_wr_c  = wr_c & (off_c == OFF_TAC);

    gb_timer_prescaler u_prescaler (
        .clk     (clk),
        .reset   (reset),
        .div_clr (div_wr_c),
        .tac     (tac),
        .div     (div_c),
        .tick_c  (tick_c)
    );

    // Combinational read port
    always_comb begin
        dsel = read & hit_c & ~reset;
        dout = '0;
        if (dsel) begin
            case (off_c)
                OFF_DIV:  dout = div_c;
                OFF_TIMA: dout = tima;
                OFF_TMA:  dout = tma;
                default:  dout = {5'b11111, tac};
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            ovf_cnt <= '0;
            tima    <= '0;
            tma     <= '0;
            tac     <= '0;
            irq     <= 1'b0;
        end else begin
            state   <= state_n;
            ovf_cnt <= ovf_cnt_n;
            tima    <= tima_n;
            tma     <= tma_n;
            tac     <= tac_n;
            irq     <= irq_n;
        end
    end

    // Overflow/reload sequencer; CPU writes to TIMA take priority over ticks
    always_comb begin
        state_n   = state;
        ovf_cnt_n = ovf_cnt;
        tima_n    = tima;
        tma_n     = tma_wr_c ? din : tma;
        tac_n     = tac_wr_c ? din[TAC_W-1:0] : tac;

        case (state)
            ST_IDLE: begin
                if (tima_wr_c) begin
                    tima_n = din;
                end else if (tick_c) begin
                    tima_n = tima + DATA_W'(1);
                    if (tima == '1) begin
                        state_n   = ST_OVF;
                        ovf_cnt_n = OVF_LAST;
                    end
                end
            end
            ST_OVF: begin
                if (tima_wr_c) begin
                    tima_n  = din;
                    state_n = ST_IDLE;
                end else if (ovf_cnt == '0) begin
                    tima_n  = tma_n;
                    state_n = ST_RELOAD;
                end else begin
                    ovf_cnt_n = ovf_cnt - OVF_W'(1);
                    if (tick_c) begin
                        tima_n = tima + DATA_W'(1);
                    end
                end
            end
            ST_RELOAD: begin
                // TIMA writes are dropped here; a TMA write lands in TIMA too
                tima_n  = tma_n;
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase

        irq_n = (state_n == ST_RELOAD);
    end

endmodule

// File: tb/tb_gb_timer.sv
// Directed bench for gb_timer: expected {dsel, irq, dout} queued with each
// stimulus step and compared after the clock edge that produces it.
module tb_gb_timer;

    localparam logic [15:0] BASE = 16'hFF04;

    typedef struct {
        string      tag;
        logic [9:0] val;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [15:0] adr;
    logic [7:0]  din;
    logic        read;
    logic        write;
    logic [7:0]  dout;
    logic        dsel;
    logic        irq;

    exp_t sb[$];
    int   n_chk;
    int   n_err;

    gb_timer #(.BASE(BASE)) dut (
        .clk   (clk),
        .reset (reset),
        .adr   (adr),
        .din   (din),
        .read  (read),
        .write (write),
        .dout  (dout),
        .dsel  (dsel),
        .irq   (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "simulation did not finish");
    end

    // One bus cycle; when chk is set the expectation is queued and then
    // checked against {dsel, irq, dout} just after the edge.
    task automatic cyc(input logic [15:0] a, input logic [7:0] d, input logic r,
                       input logic w, input bit chk, input logic [9:0] exp_v,
                       input string tag);
        exp_t       e;
        logic [9:0] obs;
        adr   = a;
        din   = d;
        read  = r;
        write = w;
        if (chk) sb.push_back('{tag: tag, val: exp_v});
        @(posedge clk);
        #1;
        if (chk) begin
            e   = sb.pop_front();
            obs = {dsel, irq, dout};
            n_chk++;
            assert (obs === e.val) else begin
                n_err++;
                $error("FAIL %s: observed {dsel,irq,dout}=%h expected=%h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic wr(input logic [1:0] off, input logic [7:0] d);
        cyc(BASE + 16'(off), d, 1'b0, 1'b1, 1'b0, 10'h000, "");
    endtask

    task automatic rd(input logic [1:0] off, input logic [7:0] exp_d, input logic exp_irq,
                      input string tag);
        cyc(BASE + 16'(off), 8'h00, 1'b1, 1'b0, 1'b1, {1'b1, exp_irq, exp_d}, tag);
    endtask

    // Leaves TIMA=0xFF, TMA=tma_v; the tick forced by the final TAC write
    // overflows TIMA on the very next edge.
    task automatic setup_ovf(input logic [7:0] tma_v);
        wr(2'd3, 8'h00);
        wr(2'd2, tma_v);
        wr(2'd1, 8'hFF);
        wr(2'd0, 8'h00);
        wr(2'd3, 8'h05);
        for (int i = 0; i < 7; i++) rd(2'd1, 8'hFF, 1'b0, "ovf_pre");
        wr(2'd3, 8'h04);
    endtask

    // Counter reaches 0x0008 with bit 3 selected, then DIV is cleared.
    task automatic glitch_setup(input logic [7:0] tima_v);
        wr(2'd3, 8'h00);
        wr(2'd1, tima_v);
        wr(2'd0, 8'h00);
        wr(2'd3, 8'h05);
        for (int i = 0; i < 7; i++) rd(2'd1, tima_v, 1'b0, "glitch_pre");
        wr(2'd0, 8'h00);
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        reset = 1'b1;
        adr   = 16'h0000;
        din   = 8'h00;
        read  = 1'b0;
        write = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        cyc(BASE + 16'd1, 8'h00, 1'b1, 1'b0, 1'b1, 10'h000, "rst_dsel_low");
        reset = 1'b0;

        // Prescale bit 3: TIMA steps once every 16 clocks from the first edge
        wr(2'd3, 8'h05);
        for (int i = 2; i <= 49; i++)
            rd(2'd1, 8'((i - 1) / 16), 1'b0, $sformatf("div16_tima_e%0d", i));

        // Overflow: four cycles of 0x00, then TMA with a single irq cycle
        setup_ovf(8'hAB);
        for (int i = 0; i < 4; i++) rd(2'd1, 8'h00, 1'b0, $sformatf("ovf_zero_%0d", i));
        rd(2'd1, 8'hAB, 1'b1, "reload_irq");
        rd(2'd1, 8'hAB, 1'b0, "after_reload_1");
        rd(2'd1, 8'hAB, 1'b0, "after_reload_2");

        // TIMA write two cycles into OVF cancels reload and irq
        setup_ovf(8'hAB);
        rd(2'd1, 8'h00, 1'b0, "cancel_ovf_0");
        rd(2'd1, 8'h00, 1'b0, "cancel_ovf_1");
        wr(2'd1, 8'h55);
        for (int i = 0; i < 6; i++) rd(2'd1, 8'h55, 1'b0, $sformatf("cancel_hold_%0d", i));

        // DIV write while the selected bit is high increments TIMA
        glitch_setup(8'h10);
        rd(2'd1, 8'h11, 1'b0, "div_glitch_tima");
        rd(2'd0, 8'h00, 1'b0, "div_cleared");

        // TIMA write on the tick cycle beats the increment
        glitch_setup(8'h20);
        wr(2'd1, 8'h40);
        rd(2'd1, 8'h40, 1'b0, "wr_beats_inc");

        // TMA write during RELOAD also lands in TIMA
        setup_ovf(8'hAB);
        for (int i = 0; i < 4; i++) rd(2'd1, 8'h00, 1'b0, "tmawr_ovf");
        rd(2'd1, 8'hAB, 1'b1, "tmawr_reload_irq");
        wr(2'd2, 8'h77);
        rd(2'd1, 8'h77, 1'b0, "tma_wr_in_reload_tima");
        rd(2'd2, 8'h77, 1'b0, "tma_wr_in_reload_tma");

        // TIMA write during RELOAD is ignored
        setup_ovf(8'hAB);
        for (int i = 0; i < 4; i++) rd(2'd1, 8'h00, 1'b0, "timawr_ovf");
        rd(2'd1, 8'hAB, 1'b1, "timawr_reload_irq");
        wr(2'd1, 8'h33);
        rd(2'd1, 8'hAB, 1'b0, "tima_wr_ignored_reload");

        // TAC read-back and address decode
        wr(2'd3, 8'hFF);
        rd(2'd3, 8'hFF, 1'b0, "tac_ff");
        wr(2'd3, 8'h00);
        rd(2'd3, 8'hF8, 1'b0, "tac_00");
        rd(2'd2, 8'hAB, 1'b0, "tma_readback");
        cyc(16'hFF08, 8'h00, 1'b1, 1'b0, 1'b1, 10'h000, "unmapped_hi");
        cyc(16'hFF03, 8'h00, 1'b1, 1'b0, 1'b1, 10'h000, "unmapped_lo");
        cyc(BASE + 16'd1, 8'h00, 1'b0, 1'b0, 1'b1, 10'h000, "no_read_strobe");

        // Reset in the middle of OVF: no irq, registers back to reset values
        setup_ovf(8'hAB);
        rd(2'd1, 8'h00, 1'b0, "rst_ovf_0");
        rd(2'd1, 8'h00, 1'b0, "rst_ovf_1");
        reset = 1'b1;
        cyc(BASE + 16'd1, 8'h00, 1'b1, 1'b0, 1'b1, 10'h000, "rst_mid_ovf_dsel");
        reset = 1'b0;
        for (int i = 0; i < 6; i++) rd(2'd1, 8'h00, 1'b0, $sformatf("rst_no_irq_%0d", i));
        rd(2'd0, 8'h00, 1'b0, "rst_div");
        rd(2'd2, 8'h00, 1'b0, "rst_tma");
        rd(2'd3, 8'hF8, 1'b0, "rst_tac");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
